// File: rtl/cpu_lsu_if.sv
// ============================================================================
//  Module      : cpu_lsu_if
//  Description : Core request, data-memory and MMIO strobe bundle of cpu_lsu.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_lsu_if #(
    parameter int MMIO_AW = 2
);
    logic               lsu_valid_i;
    logic               lsu_we_i;
    logic [1:0]         lsu_size_i;
    logic               lsu_unsigned_i;
    logic [31:0]        lsu_addr_i;
    logic [31:0]        lsu_wdata_i;
    logic               lsu_busy_o;
    logic               lsu_done_o;
    logic [31:0]        lsu_rdata_o;
    logic               lsu_err_o;
    logic [1:0]         lsu_cause_o;
    logic               mem_req_o;
    logic               mem_we_o;
    logic [31:0]        mem_addr_o;
    logic [3:0]         mem_be_o;
    logic [31:0]        mem_wdata_o;
    logic               mem_gnt_i;
    logic               mem_rvalid_i;
    logic [31:0]        mem_rdata_i;
    logic               mmio_sel_o;
    logic               mmio_rd_o;
    logic               mmio_wr_o;
    logic [MMIO_AW-1:0] mmio_addr_o;
    logic [7:0]         mmio_wdata_o;
    logic [7:0]         mmio_rdata_i;

    // LSU side
    modport slave (
        input  lsu_valid_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
        output lsu_busy_o, lsu_done_o, lsu_rdata_o, lsu_err_o, lsu_cause_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output mmio_sel_o, mmio_rd_o, mmio_wr_o, mmio_addr_o, mmio_wdata_o,
        input  mmio_rdata_i
    );

    // Core plus memory/MMIO side
    modport master (
        output lsu_valid_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_busy_o, lsu_done_o, lsu_rdata_o, lsu_err_o, lsu_cause_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  mmio_sel_o, mmio_rd_o, mmio_wr_o, mmio_addr_o, mmio_wdata_o,
        output mmio_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/cpu_lsu.sv
// ============================================================================
//  Module      : cpu_lsu
//  Description : Load/store unit routing requests to word memory or byte MMIO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_lsu #(
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
    parameter int          MMIO_SPAN_LOG2 = 4,
    parameter int          MMIO_AW        = 2,
    parameter int          TIMEOUT        = 16
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    cpu_lsu_if.slave  bus
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MREQ  = 3'd1,
        S_MWAIT = 3'd2,
        S_MMIO  = 3'd3,
        S_MRD   = 3'd4,
        S_ERR   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;
    logic [TW-1:0] w_tmo_inc;
    logic          w_tmo_hit;
    logic [1:0]    w_cause;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [1:0]    r_lane;
    logic          w_accept;
    logic          w_misal;
    logic          w_in_mmio;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_lane_word;
    logic [31:0]   w_ld_ext;
    logic          w_load_cap;

    assign w_accept  = (r_state == S_IDLE) && bus.lsu_valid_i;
    assign w_misal   = (bus.lsu_size_i == 2'd3)
                     || ((bus.lsu_size_i == 2'd1) && bus.lsu_addr_i[0])
                     || ((bus.lsu_size_i == 2'd2) && (bus.lsu_addr_i[1:0] != 2'b00));
    assign w_in_mmio = (bus.lsu_addr_i[31:MMIO_SPAN_LOG2] == MMIO_BASE[31:MMIO_SPAN_LOG2]);
    assign w_tmo_inc = r_tmo + 1'b1;
    assign w_tmo_hit = (TIMEOUT != 0) && (w_tmo_inc == TW'(TIMEOUT));
    assign w_load_cap = ((r_state == S_MWAIT) && bus.mem_rvalid_i) || (r_state == S_MRD);

    always_comb begin
        w_be        = 4'h0;
        w_wdata_rep = bus.lsu_wdata_i;
        case (bus.lsu_size_i)
            2'd0: begin
                w_be        = 4'b0001 << bus.lsu_addr_i[1:0];
                w_wdata_rep = {4{bus.lsu_wdata_i[7:0]}};
            end
            2'd1: begin
                w_be        = 4'b0011 << bus.lsu_addr_i[1:0];
                w_wdata_rep = {2{bus.lsu_wdata_i[15:0]}};
            end
            2'd2: w_be = 4'hF;
            default: w_be = 4'h0;
        endcase
    end

    // MMIO data is already a single byte; memory data is shifted to its lane
    always_comb begin
        w_lane_word = (r_state == S_MRD) ? {24'h0, bus.mmio_rdata_i}
                                         : (bus.mem_rdata_i >> {r_lane, 3'b000});
        case (r_size)
            2'd0:    w_ld_ext = r_uns ? {24'h0, w_lane_word[7:0]}
                                      : {{24{w_lane_word[7]}}, w_lane_word[7:0]};
            2'd1:    w_ld_ext = r_uns ? {16'h0, w_lane_word[15:0]}
                                      : {{16{w_lane_word[15]}}, w_lane_word[15:0]};
            default: w_ld_ext = w_lane_word;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_cause     = 2'd0;
        case (r_state)
            S_IDLE: begin
                w_tmo_nxt = '0;
                if (bus.lsu_valid_i) begin
                    if (w_misal) begin
                        w_state_nxt = S_ERR;
                        w_cause     = 2'd1;
                    end else if (w_in_mmio && (bus.lsu_size_i != 2'd0)) begin
                        w_state_nxt = S_ERR;
                        w_cause     = 2'd3;
                    end else if (w_in_mmio) begin
                        w_state_nxt = S_MMIO;
                    end else begin
                        w_state_nxt = S_MREQ;
                    end
                end
            end
            S_MREQ: begin
                w_tmo_nxt = w_tmo_inc;
                if (bus.mem_gnt_i) begin
                    w_state_nxt = r_we ? S_DONE : S_MWAIT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                    w_cause     = 2'd2;
                end
            end
            S_MWAIT: begin
                w_tmo_nxt = w_tmo_inc;
                if (bus.mem_rvalid_i) begin
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                    w_cause     = 2'd2;
                end
            end
            S_MMIO:  w_state_nxt = r_we ? S_DONE : S_MRD;
            S_MRD:   w_state_nxt = S_DONE;
            S_ERR:   w_state_nxt = S_IDLE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state so they line up with r_state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_tmo            <= '0;
            r_we             <= 1'b0;
            r_size           <= 2'd0;
            r_uns            <= 1'b0;
            r_lane           <= 2'd0;
            bus.lsu_busy_o   <= 1'b0;
            bus.lsu_done_o   <= 1'b0;
            bus.lsu_rdata_o  <= '0;
            bus.lsu_err_o    <= 1'b0;
            bus.lsu_cause_o  <= 2'd0;
            bus.mem_req_o    <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_be_o     <= 4'h0;
            bus.mem_wdata_o  <= '0;
            bus.mmio_sel_o   <= 1'b0;
            bus.mmio_rd_o    <= 1'b0;
            bus.mmio_wr_o    <= 1'b0;
            bus.mmio_addr_o  <= '0;
            bus.mmio_wdata_o <= 8'h0;
        end else begin
            r_state          <= w_state_nxt;
            r_tmo            <= w_tmo_nxt;
            bus.lsu_busy_o   <= (w_state_nxt != S_IDLE);
            bus.lsu_done_o   <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
            bus.lsu_err_o    <= (w_state_nxt == S_ERR);
            bus.lsu_cause_o  <= (w_state_nxt == S_ERR) ? w_cause : 2'd0;
            bus.mem_req_o    <= (w_state_nxt == S_MREQ);
            // MMIO is only ever entered straight from IDLE, so the live we input applies
            bus.mmio_sel_o   <= (w_state_nxt == S_MMIO);
            bus.mmio_rd_o    <= (w_state_nxt == S_MMIO) && !bus.lsu_we_i;
            bus.mmio_wr_o    <= (w_state_nxt == S_MMIO) && bus.lsu_we_i;
            if (w_accept) begin
                r_we             <= bus.lsu_we_i;
                r_size           <= bus.lsu_size_i;
                r_uns            <= bus.lsu_unsigned_i;
                r_lane           <= bus.lsu_addr_i[1:0];
                bus.mem_we_o     <= bus.lsu_we_i;
                bus.mem_addr_o   <= {bus.lsu_addr_i[31:2], 2'b00};
                bus.mem_be_o     <= w_be;
                bus.mem_wdata_o  <= w_wdata_rep;
                bus.mmio_addr_o  <= bus.lsu_addr_i[MMIO_AW-1:0];
                bus.mmio_wdata_o <= bus.lsu_wdata_i[7:0];
            end
            if (w_load_cap) begin
                bus.lsu_rdata_o <= w_ld_ext;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_lsu.sv
// ============================================================================
//  Module      : tb_cpu_lsu
//  Description : Directed vector bench for cpu_lsu with scripted memory/MMIO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_lsu;

    localparam int P_MEM  = 1;
    localparam int P_MMIO = 2;
    localparam int P_ERR  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;    // memory word or MMIO byte returned
        int          dly;    // extra cycles before gnt
        int          path;
        logic [3:0]  be;
        logic [31:0] wd;     // expected mem_wdata_o or mmio_wdata_o
        logic [31:0] oaddr;  // expected mem_addr_o or mmio_addr_o
        logic [1:0]  cause;
        int          lat;    // cycles after accept edge until done is visible
        logic [31:0] rdata;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    cpu_lsu_if #(.MMIO_AW(2)) bus ();

    cpu_lsu #(
        .MMIO_BASE      (32'h8000_0000),
        .MMIO_SPAN_LOG2 (4),
        .MMIO_AW        (2),
        .TIMEOUT        (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rsp, input int dly, input int path,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] oaddr, input logic [1:0] cause,
                                input int lat, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rsp = rsp; v.dly = dly; v.path = path; v.be = be; v.wd = wd;
        v.oaddr = oaddr; v.cause = cause; v.lat = lat; v.rdata = rdata;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.lsu_valid_i    = 1'b0;
        bus.mem_gnt_i      = 1'b0;
        bus.mem_rvalid_i   = 1'b0;
        bus.mem_rdata_i    = 32'h0;
        bus.mmio_rdata_i   = 8'h0;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.lsu_valid_i    = 1'b1;
        bus.lsu_we_i       = we;
        bus.lsu_size_i     = size;
        bus.lsu_unsigned_i = uns;
        bus.lsu_addr_i     = addr;
        bus.lsu_wdata_i    = wdata;
        @(negedge clk);
        // scramble request inputs: the unit must have captured them
        bus.lsu_valid_i    = 1'b0;
        bus.lsu_we_i       = ~we;
        bus.lsu_size_i     = 2'd3;
        bus.lsu_unsigned_i = ~uns;
        bus.lsu_addr_i     = 32'hFFFF_FFFF;
        bus.lsu_wdata_i    = 32'h5A5A_5A5A;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          reqc, selc, rdc, wrc, nbusy, lat;
        bit          seen, gnt_prev, rd_prev;
        logic [3:0]  be_s;
        logic [31:0] wd_s, ad_s, rdata_s;
        logic        we_s, err_s;
        logic [1:0]  cause_s;
        string       p;
        p = $sformatf("v%0d", idx);
        reqc = 0; selc = 0; rdc = 0; wrc = 0; nbusy = 0; lat = -1;
        seen = 0; gnt_prev = 0; rd_prev = 0;
        be_s = 4'h0; wd_s = 32'h0; ad_s = 32'h0; we_s = 1'b0;
        err_s = 1'b0; cause_s = 2'd0; rdata_s = 32'h0;
        issue(v.we, v.size, v.uns, v.addr, v.wdata);
        for (int k = 1; k <= 40 && !seen; k++) begin
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = 32'h0;
            bus.mmio_rdata_i = ~v.rsp[7:0];
            if (rd_prev) bus.mmio_rdata_i = v.rsp[7:0];
            if (gnt_prev && !v.we) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = v.rsp;
            end
            gnt_prev = 0;
            rd_prev  = 0;
            if (!bus.lsu_busy_o) nbusy++;
            if (bus.mem_req_o) begin
                reqc++;
                be_s = bus.mem_be_o; wd_s = bus.mem_wdata_o;
                ad_s = bus.mem_addr_o; we_s = bus.mem_we_o;
                if (reqc == v.dly + 1) begin
                    bus.mem_gnt_i = 1'b1;
                    gnt_prev      = 1;
                end
            end
            if (bus.mmio_sel_o) begin
                selc++;
                ad_s = {30'h0, bus.mmio_addr_o};
                wd_s = {24'h0, bus.mmio_wdata_o};
                if (bus.mmio_rd_o) rd_prev = 1;
            end
            if (bus.mmio_rd_o) rdc++;
            if (bus.mmio_wr_o) wrc++;
            if (bus.lsu_done_o) begin
                seen = 1; lat = k;
                err_s = bus.lsu_err_o; cause_s = bus.lsu_cause_o; rdata_s = bus.lsu_rdata_o;
            end
            if (!seen) @(negedge clk);
        end
        @(negedge clk);
        idle_inputs();
        chk({p, ".latency"}, lat, v.lat);
        chk({p, ".busy_gaps"}, nbusy, 0);
        chk({p, ".done_pulse"}, {bus.lsu_done_o, bus.lsu_busy_o}, 2'b00);
        chk({p, ".err"}, err_s, (v.path == P_ERR));
        chk({p, ".cause"}, cause_s, v.cause);
        chk({p, ".rdata"}, rdata_s, v.rdata);
        if (v.path == P_MEM) begin
            chk({p, ".req_cycles"}, reqc, v.dly + 1);
            chk({p, ".be"}, be_s, v.be);
            chk({p, ".mem_wdata"}, wd_s, v.wd);
            chk({p, ".mem_addr"}, ad_s, v.oaddr);
            chk({p, ".mem_we"}, we_s, v.we);
            chk({p, ".mmio_sel"}, selc, 0);
        end else if (v.path == P_MMIO) begin
            chk({p, ".sel_cycles"}, selc, 1);
            chk({p, ".rd_cycles"}, rdc, !v.we);
            chk({p, ".wr_cycles"}, wrc, v.we);
            chk({p, ".mmio_addr"}, ad_s, v.oaddr);
            chk({p, ".mmio_wdata"}, wd_s, v.wd);
            chk({p, ".mem_req"}, reqc, 0);
        end else begin
            chk({p, ".no_req"}, reqc + selc, 0);
        end
    endtask

    initial begin
        int reqc, lat, extra_done, nbusy;
        logic [1:0] cause_s;
        logic err_s, req_at_done;
        logic [31:0] addr_s;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.lsu_we_i = 1'b0; bus.lsu_size_i = 2'd0; bus.lsu_unsigned_i = 1'b0;
        bus.lsu_addr_i = 32'h0; bus.lsu_wdata_i = 32'h0;
        idle_inputs();

        //       we  sz  u  addr          wdata         rsp           d  path    be     wd            oaddr         c  lat rdata
        vecs.push_back(mk(1, 2, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        2, P_MEM,  4'hF, 32'hDEAD_BEEF, 32'h0000_0100, 0, 4, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, P_MEM,  4'h8, 32'h0,        32'h0000_0100, 0, 3, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, P_MEM,  4'h8, 32'h0,        32'h0000_0100, 0, 3, 32'h0000_0080));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 1, P_MEM,  4'hC, 32'h0,        32'h0000_0100, 0, 4, 32'hFFFF_BEEF));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0101, 32'h0,        32'h0,         0, P_ERR,  4'h0, 32'h0,        32'h0,         1, 1, 32'hFFFF_BEEF));
        vecs.push_back(mk(0, 2, 0, 32'h8000_0000, 32'h0,        32'h0,         0, P_ERR,  4'h0, 32'h0,        32'h0,         3, 1, 32'hFFFF_BEEF));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0001, 32'h0000_0041, 32'h0,        0, P_MMIO, 4'h0, 32'h41,       32'h1,         0, 2, 32'hFFFF_BEEF));
        vecs.push_back(mk(0, 0, 1, 32'h8000_0002, 32'h0,        32'h7F,        0, P_MMIO, 4'h0, 32'h0,        32'h2,         0, 3, 32'h0000_007F));
        vecs.push_back(mk(0, 0, 0, 32'h8000_0003, 32'h0,        32'h85,        0, P_MMIO, 4'h0, 32'h0,        32'h3,         0, 3, 32'hFFFF_FF85));
        vecs.push_back(mk(1, 0, 0, 32'h0000_0202, 32'h1234_56AB, 32'h0,        1, P_MEM,  4'h4, 32'hABAB_ABAB, 32'h0000_0200, 0, 3, 32'hFFFF_FF85));
        vecs.push_back(mk(1, 1, 0, 32'h0000_0206, 32'h1234_CAFE, 32'h0,        0, P_MEM,  4'hC, 32'hCAFE_CAFE, 32'h0000_0204, 0, 2, 32'hFFFF_FF85));
        vecs.push_back(mk(0, 3, 0, 32'h0000_0100, 32'h0,        32'h0,         0, P_ERR,  4'h0, 32'h0,        32'h0,         1, 1, 32'hFFFF_FF85));
        vecs.push_back(mk(1, 2, 0, 32'h0000_0106, 32'h1111_1111, 32'h0,        0, P_ERR,  4'h0, 32'h0,        32'h0,         1, 1, 32'hFFFF_FF85));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, 32'h0,        32'h1234_8001, 0, P_MEM,  4'h3, 32'h0,        32'h0000_0100, 0, 3, 32'h0000_8001));
        vecs.push_back(mk(0, 0, 0, 32'h8000_0010, 32'h0,        32'h1122_3344, 0, P_MEM,  4'h1, 32'h0,        32'h8000_0010, 0, 3, 32'h0000_0044));
        vecs.push_back(mk(1, 0, 0, 32'h8000_000F, 32'h0000_00C3, 32'h0,        0, P_MMIO, 4'h0, 32'hC3,       32'h3,         0, 2, 32'h0000_0044));
        vecs.push_back(mk(0, 2, 0, 32'h7FFF_FFFC, 32'h0,        32'hCAFE_F00D, 3, P_MEM,  4'hF, 32'h0,        32'h7FFF_FFFC, 0, 6, 32'hCAFE_F00D));
        vecs.push_back(mk(1, 1, 0, 32'h8000_0002, 32'h0000_1234, 32'h0,        0, P_ERR,  4'h0, 32'h0,        32'h0,         3, 1, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0100, 32'h0,        32'h0000_7FFF, 0, P_MEM,  4'h3, 32'h0,        32'h0000_0100, 0, 3, 32'h0000_7FFF));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.busy_done_err", {bus.lsu_busy_o, bus.lsu_done_o, bus.lsu_err_o}, 3'b000);
        chk("reset.cause", bus.lsu_cause_o, 2'd0);
        chk("reset.rdata", bus.lsu_rdata_o, 32'h0);
        chk("reset.mem", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}, 6'h0);
        chk("reset.mem_addr", bus.mem_addr_o, 32'h0);
        chk("reset.mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("reset.mmio", {bus.mmio_sel_o, bus.mmio_rd_o, bus.mmio_wr_o, bus.mmio_addr_o, bus.mmio_wdata_o}, 13'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Timeout: no gnt ever; a request issued while busy must be ignored
        reqc = 0; lat = -1; err_s = 1'b0; cause_s = 2'd0; req_at_done = 1'b1; addr_s = 32'h0;
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0300, 32'h0);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            bus.lsu_valid_i = (k == 3);
            bus.lsu_addr_i  = 32'h0000_0500;
            bus.lsu_size_i  = 2'd2;
            if (bus.mem_req_o) begin
                reqc++;
                addr_s = bus.mem_addr_o;
            end
            if (bus.lsu_done_o) begin
                lat = k; err_s = bus.lsu_err_o; cause_s = bus.lsu_cause_o;
                req_at_done = bus.mem_req_o;
            end
            if (lat < 0) @(negedge clk);
        end
        bus.lsu_valid_i = 1'b0;
        chk("tmo.req_cycles", reqc, 16);
        chk("tmo.latency", lat, 17);
        chk("tmo.err", err_s, 1'b1);
        chk("tmo.cause", cause_s, 2'd2);
        chk("tmo.req_dropped", req_at_done, 1'b0);
        chk("tmo.mem_addr", addr_s, 32'h0000_0300);
        chk("tmo.rdata_held", bus.lsu_rdata_o, 32'h0000_7FFF);
        extra_done = 0; nbusy = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.mem_rvalid_i = (k == 1);
            bus.mem_gnt_i    = (k == 2);
            bus.mem_rdata_i  = 32'hFFFF_FFFF;
            if (bus.lsu_done_o) extra_done++;
            if (bus.lsu_busy_o || bus.mem_req_o) nbusy++;
        end
        idle_inputs();
        chk("tmo.late_rvalid_done", extra_done, 0);
        chk("tmo.late_rvalid_busy", nbusy, 0);

        // Reset while waiting in MWAIT
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        chk("rstmid.in_wait", {bus.lsu_busy_o, bus.mem_req_o, bus.lsu_done_o}, 3'b100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.idle", {bus.lsu_busy_o, bus.mem_req_o, bus.lsu_done_o, bus.lsu_err_o}, 4'b0000);
        chk("rstmid.rdata", bus.lsu_rdata_o, 32'h0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1357_9BDF;
        @(negedge clk);
        idle_inputs();
        chk("rstmid.stale_rvalid", {bus.lsu_busy_o, bus.lsu_done_o}, 2'b00);
        @(negedge clk);
        chk("rstmid.stale_rdata", bus.lsu_rdata_o, 32'h0);
        run_vec(100, mk(0, 2, 0, 32'h0000_0404, 32'h0, 32'h0BAD_F00D, 0, P_MEM, 4'hF, 32'h0,
                        32'h0000_0404, 0, 3, 32'h0BAD_F00D));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
